reg_file: RTL and testbench

- RV32 integer register file (x0–x31) for the decode stage: two asynchronous read ports (rs1, rs2) and one synchronous write port driven by writeback.
- x0 is hardwired to zero.
- Includes an internal write-to-read bypass, so decode sees the value writeback is committing in the same cycle. The pipeline forwarding unit covers only EX and MEM, so this bypass is required.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/reg_file.sv | 65 ++++++
 tb/tb_reg_file.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// RV32 integer-core shared constants used by decode, forwarding and the register file.
// Latency: none; this package holds only constants and types.
// Backpressure: not applicable; there are no ports.
package riscv_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   // Architectural zero register index, shared with the forwarding logic.
   localparam reg_idx_t REG_ZERO = 5'd0;

endpackage : riscv_pkg

// File: rtl/reg_file.sv
// RV32 register file: x0 hardwired to zero, two combinational read ports, one write port.
// Latency: reads are zero-cycle; a write commits on the next rising clk edge.
// Backpressure: none; every write is accepted, and the last write to a register wins.
module reg_file
   import riscv_pkg::*;
#(
   parameter int XLEN   = riscv_pkg::XLEN,
   parameter int NREGS  = 32,
   parameter bit BYPASS = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [REG_IDX_W-1:0] rs1,
   output logic [XLEN-1:0]      rdata1,
   input  logic [REG_IDX_W-1:0] rs2,
   output logic [XLEN-1:0]      rdata2,
   input  logic [REG_IDX_W-1:0] wreg,
   input  logic [XLEN-1:0]      wdata,
   input  logic                 wen
);

   // x0 has no storage, so the array starts at index 1.
   logic [XLEN-1:0] regs [1:NREGS-1];

   // A write is forwarded only when it will really commit on this edge.
   // During reset it will not commit, so reads see the stored contents.
   logic wr_live;
   assign wr_live = BYPASS && reset_n && wen && (wreg != REG_ZERO);

   // Array update: reset clears every register and takes priority; writes to x0 are dropped.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 1; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wen && (wreg != REG_ZERO)) begin
         regs[wreg] <= wdata;
      end
   end

   // Port 1 read mux: zero for x0, the live write data on an index match, else the stored value.
   always_comb begin
      rdata1 = '0;
      if (rs1 != REG_ZERO) begin
         if (wr_live && (wreg == rs1)) begin
            rdata1 = wdata;
         end else begin
            rdata1 = regs[rs1];
         end
      end
   end

   // Port 2 read mux: same rules as port 1, evaluated independently.
   always_comb begin
      rdata2 = '0;
      if (rs2 != REG_ZERO) begin
         if (wr_live && (wreg == rs2)) begin
            rdata2 = wdata;
         end else begin
            rdata2 = regs[rs2];
         end
      end
   end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Randomized and directed bench for reg_file with a scoreboard and an array reference model.
// Latency: expectations are checked 1 time unit after the inputs change, well away from the edge.
// Backpressure: none; one expectation pair is pushed per driven cycle.
module tb_reg_file;

   logic        clk;
   logic        reset_n;
   logic [4:0]  rs1, rs2, wreg;
   logic [31:0] rdata1, rdata2, wdata;
   logic        wen;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: committed architectural state. x0 is never written.
   logic [31:0] model [0:31];

   // Scoreboard queues.
   logic [31:0] exp1_q[$];
   logic [31:0] exp2_q[$];
   string       name_q[$];
   event        drv_ev;

   reg_file #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .rs1     (rs1),
      .rdata1  (rdata1),
      .rs2     (rs2),
      .rdata2  (rdata2),
      .wreg    (wreg),
      .wdata   (wdata),
      .wen     (wen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected read value from the architectural rules.
   function automatic logic [31:0] exp_read(input logic [4:0] idx, input logic rn,
                                            input logic we, input logic [4:0] wr,
                                            input logic [31:0] wd);
      if (idx == 5'd0)                   return 32'd0;
      if (rn && we && (wr == idx))       return wd;
      return model[idx];
   endfunction

   // Drive one cycle, push the expectation, then advance the model past the coming edge.
   task automatic step(input logic rn, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                       input string nm);
      @(negedge clk);
      reset_n = rn; wen = we; wreg = wr; wdata = wd; rs1 = r1; rs2 = r2;
      exp1_q.push_back(exp_read(r1, rn, we, wr, wd));
      exp2_q.push_back(exp_read(r2, rn, we, wr, wd));
      name_q.push_back(nm);
      -> drv_ev;
      if (!rn) begin
         for (int i = 0; i < 32; i++) model[i] = 32'd0;
      end else if (we && (wr != 5'd0)) begin
         model[wr] = wd;
      end
   endtask

   // Monitor: whenever a new input set is presented, compare both ports against the queue head.
   initial begin
      logic [31:0] e1, e2;
      string       nm;
      forever begin
         @(drv_ev);
         #1;
         if (exp1_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_underflow: queue empty, required one entry");
         end else begin
            e1 = exp1_q.pop_front();
            e2 = exp2_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (rdata1 !== e1) begin
               n_fail++;
               $display("FAIL %s rdata1: got %h, required %h (rs1=%0d)", nm, rdata1, e1, rs1);
            end
            n_checks++;
            if (rdata2 !== e2) begin
               n_fail++;
               $display("FAIL %s rdata2: got %h, required %h (rs2=%0d)", nm, rdata2, e2, rs2);
            end
         end
      end
   end

   initial begin
      int waited;
      logic [4:0] r1, r2, wr;
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      reset_n = 1'b0; wen = 1'b0; wreg = 5'd0; wdata = 32'd0; rs1 = 5'd0; rs2 = 5'd0;
      // Bring-up reset; storage is undefined before it, so nothing is checked here.
      repeat (3) @(negedge clk);

      // Reset clears a written register; stored value stays visible while reset is held.
      step(1, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, "pre_reset_bypass");
      step(0, 0, 5'd0, 32'd0,        5'd5, 5'd5, "in_reset_stored");
      step(0, 0, 5'd0, 32'd0,        5'd5, 5'd5, "in_reset_cleared");
      step(1, 0, 5'd0, 32'd0,        5'd5, 5'd0, "post_reset_x5");
      for (int i = 1; i < 32; i++)
         step(1, 0, 5'd0, 32'd0, 5'(i), 5'(32 - i), "post_reset_all");

      // Write / read-back at both ends of the index range.
      step(1, 1, 5'd1,  32'h12345678, 5'd0, 5'd0, "wr_x1");
      step(1, 1, 5'd31, 32'hFFFFFFFF, 5'd1, 5'd0, "wr_x31");
      step(1, 0, 5'd0,  32'd0,        5'd1, 5'd31, "readback");

      // x0 is hardwired, both during and after the attempted write.
      step(1, 1, 5'd0, 32'hAAAAAAAA, 5'd0, 5'd0, "x0_write");
      step(1, 0, 5'd0, 32'd0,        5'd0, 5'd0, "x0_after");

      // Bypass on both ports at once.
      step(1, 1, 5'd7, 32'h00000001, 5'd0, 5'd0, "wr_x7");
      step(1, 0, 5'd7, 32'h00000055, 5'd7, 5'd7, "no_bypass_wen0");
      step(1, 1, 5'd7, 32'h00000055, 5'd7, 5'd7, "bypass_both");
      step(1, 0, 5'd7, 32'h00000055, 5'd7, 5'd7, "after_bypass");

      // Reset overrides a write and disables the bypass.
      step(1, 1, 5'd3, 32'h00000042, 5'd0, 5'd0, "wr_x3");
      step(0, 1, 5'd3, 32'h00000099, 5'd3, 5'd3, "reset_vs_write");
      step(1, 0, 5'd0, 32'd0,        5'd3, 5'd7, "after_reset_vs_write");

      // Random traffic; read indices often collide with the write index to exercise bypass.
      for (int n = 0; n < 1000; n++) begin
         wr = 5'($urandom_range(0, 31));
         r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
         r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
         step(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), wr, $urandom, r1, r2,
              "random");
      end

      // Drain: the monitor must have consumed every expectation, within a bounded wait.
      waited = 0;
      while (exp1_q.size() != 0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      n_checks++;
      if (exp1_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, required 0", exp1_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_reg_file
